// File: rtl/vec_mem_seq_pkg.sv
// vec_mem_seq_pkg: shared types and defaults for the vector memory sequencer.
//   VMS_LANES / VMS_DATA_W : default lane count and lane/memory word width
//   idx_w()                : lane index width helper (at least 1 bit)
//   lane_idx_t             : lane index type for the default lane count
//   state_t                : sequencer FSM states
package vec_mem_seq_pkg;

    localparam int VMS_LANES  = 4;
    localparam int VMS_DATA_W = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VMS_IDX_W = idx_w(VMS_LANES);

    typedef logic [VMS_IDX_W-1:0] lane_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/vms_lane_ctr.sv
// vms_lane_ctr: lane index counter for the vector memory sequencer.
// One counter serves both the issue side (lane on the memory bus) and the
// load capture side (lane whose read data is returning, idx-1).
//   clk, rst : clock, async active-low reset
//   load     : restart at lane 0 (wins over inc)
//   inc      : advance one lane, wrapping after LANES-1
//   idx      : current lane index
//   last     : idx is the final lane
module vms_lane_ctr
    import vec_mem_seq_pkg::*;
#(
    parameter int LANES = VMS_LANES,
    parameter int IDX_W = idx_w(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign idx  = cnt_q;
    assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/vec_mem_seq.sv
// vec_mem_seq: serializes one LANES-wide vector load/store request into
// per-lane word accesses on a single-word data memory port, gathers load
// data into one vector and pulses rsp_valid on completion.
//   clk, rst          : clock, async active-low reset
//   req_valid/ready   : request handshake; ready only in IDLE
//   req_we/addr/wdata : store flag, lane-0 word address, packed store data
//   rsp_valid/rdata   : completion pulse; gathered load vector (held until
//                       the next load completes)
//   busy              : transfer in progress (CPU stall)
//   mem_*             : word memory port; mem_rdata returns one cycle
//                       after mem_re
// Optional: define VEC_MEM_SEQ_PERF_EN to add xfer_count, a 16-bit wrapping
// count of completed transfers.
module vec_mem_seq
    import vec_mem_seq_pkg::*;
#(
    parameter int LANES  = VMS_LANES,
    parameter int DATA_W = VMS_DATA_W,
    parameter int STRIDE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [LANES*DATA_W-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [LANES*DATA_W-1:0] rsp_rdata,
    output logic                    busy,
    output logic [31:0]             mem_addr,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
`ifdef VEC_MEM_SEQ_PERF_EN
    ,
    output logic [15:0]             xfer_count
`endif
);

    localparam int          IDX_W     = idx_w(LANES);
    localparam int          VW        = LANES * DATA_W;
    localparam logic [31:0] ADDR_STEP = 32'(STRIDE);

    state_t            state_q, state_d;
    logic [VW-1:0]     wdata_q, wdata_d;
    logic [VW-1:0]     gather_q, gather_d;
    logic [VW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic [IDX_W-1:0]  ctr_idx;
    logic              ctr_last, ctr_load, ctr_inc;
    int                nxt_i, cap_i;

    vms_lane_ctr #(
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_lane_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (ctr_load),
        .inc  (ctr_inc),
        .idx  (ctr_idx),
        .last (ctr_last)
    );

    // The lane counter always names the lane currently on the bus. Address
    // advances by STRIDE from the previous issue, so 32-bit wrap is free.
    // Load data for lane idx-1 arrives while lane idx is issued; DRAIN picks
    // up the final lane after issue has stopped.
    always_comb begin
        state_d     = state_q;
        ctr_load    = 1'b0;
        ctr_inc     = 1'b0;
        wdata_d     = wdata_q;
        gather_d    = gather_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        nxt_i       = int'(ctr_idx) + 1;
        cap_i       = int'(ctr_idx) - 1;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    ctr_load   = 1'b1;
                    wdata_d    = req_wdata;
                    gather_d   = '0;
                    mem_addr_d = req_addr;
                    busy_d     = 1'b1;
                    if (req_we) begin
                        state_d     = ST_STORE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = req_wdata[DATA_W-1:0];
                    end else begin
                        state_d  = ST_LOAD;
                        mem_re_d = 1'b1;
                    end
                end
            end
            ST_STORE: begin
                if (ctr_last) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                end else begin
                    ctr_inc     = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_STEP;
                    mem_wdata_d = wdata_q[nxt_i*DATA_W +: DATA_W];
                end
            end
            ST_LOAD: begin
                if (ctr_idx != '0) begin
                    gather_d[cap_i*DATA_W +: DATA_W] = mem_rdata;
                end
                if (ctr_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    ctr_inc    = 1'b1;
                    mem_re_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_STEP;
                end
            end
            ST_DRAIN: begin
                gather_d[(LANES-1)*DATA_W +: DATA_W] = mem_rdata;
                rsp_rdata_d = gather_d;
                rsp_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wdata_q     <= '0;
            gather_q    <= '0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdata_q     <= wdata_d;
            gather_q    <= gather_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

`ifdef VEC_MEM_SEQ_PERF_EN
    logic [15:0] xfer_count_q, xfer_count_d;

    always_comb begin
        xfer_count_d = xfer_count_q;
        if (rsp_valid_q) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_vec_mem_seq.sv
// tb_vec_mem_seq: self-checking bench for vec_mem_seq. A table of vector
// transfers is applied in a loop; expected memory accesses and responses
// are queued at drive time and checked by a monitor as the DUT produces
// them. Hand-written sequences cover the ignored request, mid-load reset
// and back-to-back transfers. Define VEC_MEM_SEQ_PERF_EN to also check
// xfer_count.
module tb_vec_mem_seq;

    localparam int LANES  = 4;
    localparam int DATA_W = 32;
    localparam int VW     = LANES * DATA_W;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [VW-1:0] wdata;
        logic [VW-1:0] rdata;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid, req_ready, req_we;
    logic [31:0]       req_addr;
    logic [VW-1:0]     req_wdata;
    logic              rsp_valid;
    logic [VW-1:0]     rsp_rdata;
    logic              busy;
    logic [31:0]       mem_addr;
    logic              mem_re, mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef VEC_MEM_SEQ_PERF_EN
    logic [15:0]       xfer_count;
`endif

    int            errors = 0;
    int            checks = 0;
    acc_t          acc_q[$];
    logic [VW-1:0] rsp_q[$];
    logic [VW-1:0] last_rd;
    logic [31:0]   mem_arr [0:255];

    always #5 clk = ~clk;

    vec_mem_seq dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef VEC_MEM_SEQ_PERF_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    // Word memory: 256 entries aliased on addr[7:0], contents addr - 0x16
    // after reset, so 0x20..0x23 read 0xA..0xD. Read data lags mem_re by one.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 32'(i) - 32'h16;
            mem_rdata <= '0;
        end else begin
            if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
            if (mem_re) mem_rdata <= mem_arr[mem_addr[7:0]];
        end
    end

    function automatic logic [VW-1:0] v4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic we, input logic [31:0] addr,
                            input logic [VW-1:0] wd, input logic [VW-1:0] rd);
        for (int i = 0; i < LANES; i++)
            acc_q.push_back('{we, addr + 32'(i), we ? wd[i*DATA_W +: DATA_W] : 32'h0});
        if (we) begin
            rsp_q.push_back(last_rd);
        end else begin
            rsp_q.push_back(rd);
            last_rd = rd;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", VW'(req_ready), VW'(1'b1));
    endtask

    // Drives one request from a negedge in IDLE, then checks completion
    // latency, busy length and the return to IDLE.
    task automatic run_xfer(input logic we, input logic [31:0] addr,
                            input logic [VW-1:0] wd, input logic [VW-1:0] rd);
        int lat, nbusy;
        bit got;
        wait_ready();
        push_exp(we, addr, wd, rd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nbusy = 0; got = 1'b0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (rsp_valid) begin
                got = 1'b1;
                lat = n;
            end
        end
        chk("rsp_latency", VW'(lat), VW'(we ? LANES + 1 : LANES + 2));
        chk("busy_cycles", VW'(nbusy), VW'(we ? LANES + 1 : LANES + 2));
        @(negedge clk);
        chk("idle_after_done", VW'({busy, req_ready, rsp_valid}), VW'(3'b010));
    endtask

    // Monitor: every strobe must match the next queued access, every
    // rsp_valid the next queued response.
    initial begin
        acc_t          e;
        logic [VW-1:0] r;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_re || mem_we) begin
                    chk("re_we_exclusive", VW'(mem_re & mem_we), '0);
                    if (acc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_access: got we=%0b addr=%h expected none", mem_we, mem_addr);
                    end else begin
                        e = acc_q.pop_front();
                        chk("mem_access", VW'({mem_we, mem_addr, mem_we ? mem_wdata : 32'h0}), VW'(e));
                    end
                end
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid with rdata %h expected none", rsp_rdata);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, r);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   rdy_seen;
        bit   got, saw_rsp;

        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        last_rd   = '0;

        tbl[0] = '{1'b1, 32'h10,       v4(1, 2, 3, 4), '0};
        tbl[1] = '{1'b0, 32'h20,       '0, v4(32'hA, 32'hB, 32'hC, 32'hD)};
        tbl[2] = '{1'b0, 32'h10,       '0, v4(1, 2, 3, 4)};
        tbl[3] = '{1'b1, 32'h40,       v4(32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h12345678), '0};
        tbl[4] = '{1'b0, 32'h3E,       '0, v4(32'h28, 32'h29, 32'hDEADBEEF, 32'h0)};
        tbl[5] = '{1'b0, 32'hFFFFFFFE, '0, v4(32'hE8, 32'hE9, 32'hFFFFFFEA, 32'hFFFFFFEB)};
        tbl[6] = '{1'b1, 32'hFFFFFFFF, v4(32'h11, 32'h22, 32'h33, 32'h44), '0};
        tbl[7] = '{1'b0, 32'h0,        '0, v4(32'h22, 32'h33, 32'h44, 32'hFFFFFFED)};

        #1 rst = 1'b0;
        #2;
        chk("reset_ctrl", VW'({req_ready, rsp_valid, busy, mem_re, mem_we}), VW'(5'b10000));
        chk("reset_bus", VW'({mem_addr, mem_wdata}), '0);
        chk("reset_rdata", rsp_rdata, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++)
            run_xfer(tbl[t].we, tbl[t].addr, tbl[t].wdata, tbl[t].rdata);

        // Request held valid through a load with a new address: ignored until
        // the IDLE cycle after DONE, then accepted once.
        wait_ready();
        push_exp(1'b0, 32'h20, '0, v4(32'hA, 32'hB, 32'hC, 32'hD));
        push_exp(1'b0, 32'h50, '0, v4(32'h3A, 32'h3B, 32'h3C, 32'h3D));
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h20;
        req_wdata = '0;
        @(posedge clk);
        #1 req_addr = 32'h50;
        rdy_seen = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n <= 6 && req_ready) rdy_seen++;
            if (n == 6) chk("ign_first_rsp", VW'(rsp_valid), VW'(1'b1));
            if (n == 7) chk("ign_idle_after_done", VW'({req_ready, busy}), VW'(2'b10));
            if (n == 8) chk("ign_second_start", VW'({busy, mem_re, mem_addr}), VW'({1'b1, 1'b1, 32'h50}));
        end
        req_valid = 1'b0;
        chk("ign_not_ready_while_busy", VW'(rdy_seen), '0);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        chk("ign_second_rsp", VW'(got), VW'(1'b1));
        repeat (4) @(negedge clk);

        // Reset while lane 2 of a load is on the bus.
        wait_ready();
        for (int i = 0; i < LANES; i++) acc_q.push_back('{1'b0, 32'h30 + 32'(i), 32'h0});
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h30;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_lane2", VW'({mem_re, mem_addr}), VW'({1'b1, 32'h32}));
        #2 rst = 1'b0;
        #1;
        chk("rst_abort_ctrl", VW'({req_ready, rsp_valid, busy, mem_re, mem_we}), VW'(5'b10000));
        chk("rst_abort_rdata", rsp_rdata, '0);
        chk("rst_abort_addr", VW'(mem_addr), '0);
        acc_q.delete();
        last_rd = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        saw_rsp = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid || mem_re || mem_we) saw_rsp = 1'b1;
        end
        chk("rst_no_activity_after", VW'(saw_rsp), '0);

        // Three transfers after reset, back to back.
        run_xfer(1'b0, 32'h20, '0, v4(32'hA, 32'hB, 32'hC, 32'hD));
        run_xfer(1'b1, 32'h60, v4(5, 6, 7, 8), '0);
        run_xfer(1'b0, 32'h60, '0, v4(5, 6, 7, 8));

        repeat (3) @(negedge clk);
        chk("queues_drained", VW'(acc_q.size() + rsp_q.size()), '0);
`ifdef VEC_MEM_SEQ_PERF_EN
        chk("xfer_count", VW'(xfer_count), VW'(16'd3));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vec_mem_seq.md
Name: vec_mem_seq

Overview:
Sequences vector loads/stores (LDV and vector store path) of the vector CPU over a single-word data memory port. Accepts one 4-lane request, serializes it into per-lane word accesses, gathers load data into one vector, and signals completion. Sits between the vector CPU execute stage and the data memory; the CPU holds the pipeline while busy is high.

Parameters:
LANES, 4, number of vector lanes per transfer
DATA_W, 32, lane / memory word width in bits
STRIDE, 1, address increment between lanes (word-addressed memory)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (state IDLE)
req_we  in  1  1 = store, 0 = load
req_addr  in  32  base address of lane 0
req_wdata  in  LANES*DATA_W  store data, lane i at bits [i*DATA_W +: DATA_W]
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  LANES*DATA_W  gathered load data, same lane packing; held until next load completes
busy  out  1  transfer in progress; CPU stall
mem_addr  out  32  memory word address
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid one cycle after mem_re

Behaviour:
- Reset (rst low, async): state IDLE; lane counter 0; req_ready=1; all other outputs 0 incl. rsp_rdata. Mid-transfer reset aborts: no further strobes, no rsp_valid, captured partial data discarded.
- FSM: IDLE, STORE, LOAD, DRAIN, DONE. All mem_* / busy / rsp outputs registered; req_ready = (state==IDLE), combinational.
- Accept at cycle k: IDLE and req_valid. Latch req_we, req_addr, req_wdata. Requests while not IDLE are ignored (not queued, not latched).
- Store: cycles k+1..k+LANES: mem_we=1, mem_addr=base+i*STRIDE, mem_wdata=lane i, i=0..LANES-1. Cycle k+LANES+1: DONE, rsp_valid=1, rsp_rdata unchanged.
- Load: cycles k+1..k+LANES: mem_re=1, mem_addr=base+i*STRIDE. mem_rdata sampled cycles k+2..k+LANES+1 into lane i (DRAIN covers last lane). Cycle k+LANES+2: DONE, rsp_valid=1, rsp_rdata = gathered vector.
- busy=1 from k+1 through DONE cycle inclusive; next cycle IDLE; back-to-back accept allowed the cycle after DONE.
- mem_re and mem_we never both high. Strobes 0 outside issue cycles; mem_addr/mem_wdata hold last value.
- Address arithmetic modulo 2^32 (wrap 0xFFFFFFFF -> 0x00000000, no error).

Optional Feature:
Macro VEC_MEM_SEQ_PERF_EN. With it: extra output xfer_count (16 bits), incremented on each rsp_valid, wraps 0xFFFF->0x0000, reset 0. Without it: port and counter absent; all other behaviour identical.

Decomposition:
- Package vec_mem_seq_pkg: LANES, DATA_W defaults, state enum type, lane index type ($clog2(LANES) bits).
- One sub-module vms_lane_ctr: lane index counter with load/increment/terminal-count flag, shared by issue and capture.

Test Plan:
- Reset: rst low mid-load at lane 2 -> next cycle all strobes 0, req_ready=1, no rsp_valid ever for that request.
- Store: req_we=1, addr 0x10, lanes {1,2,3,4} -> mem_we 4 cycles, addr 0x10..0x13, data 1..4; rsp_valid at k+5; busy 5 cycles.
- Load: addr 0x20, memory model holds 0xA,0xB,0xC,0xD -> mem_re 4 cycles, rsp_valid at k+6, rsp_rdata lane0..3 = 0xA..0xD.
- Ignored request: req_valid held high during a load with different addr -> only one transfer; second accepted the cycle after DONE.
- Wrap: load at 0xFFFFFFFE -> mem_addr 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- PERF_EN: 3 transfers -> xfer_count=3; preload 0xFFFF, one transfer -> 0x0000.
